// File: rtl/leaf_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : leaf_tx_arbiter
//  Brief   : Round-robin arbiter sharing one BFT leaf injection port, with
//            resend-driven hold of the output packet and sent/retry counters.
//  Rev     : 1.0
// ============================================================================
module leaf_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_SZ    = 3,
   parameter int PAYLOAD_SZ = 45,
   parameter int P_SZ       = 49,
   parameter int CNT_SZ     = 16,
   localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_SZ-1:0]    req_addr,
   input  logic [NUM_REQ*PAYLOAD_SZ-1:0] req_payload,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [P_SZ-1:0]               dout_leaf,
   input  logic                          resend,
   output logic                          busy,
   output logic [SRC_W-1:0]              last_src,
   output logic [CNT_SZ-1:0]             sent_cnt,
   output logic [CNT_SZ-1:0]             retry_cnt
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [P_SZ-1:0]       r_dout;
   logic [P_SZ-1:0]       w_dout_nxt;
   logic [SRC_W-1:0]      r_rr;
   logic [SRC_W-1:0]      w_rr_nxt;
   logic [SRC_W-1:0]      r_last;
   logic [SRC_W-1:0]      w_last_nxt;
   logic [CNT_SZ-1:0]     r_sent;
   logic [CNT_SZ-1:0]     r_retry;

   logic                  w_grant_found;
   logic [SRC_W-1:0]      w_grant_idx;
   int                    w_idx;
   logic                  w_load_ok;
   logic                  w_take;
   logic                  w_accept;
   logic                  w_reject;
   logic [ADDR_SZ-1:0]    w_sel_addr;
   logic [PAYLOAD_SZ-1:0] w_sel_payload;

   // Rotating priority search starting at the round-robin pointer
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_rr) + k) % NUM_REQ;
         if (!w_grant_found && req_valid[w_idx]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = SRC_W'(w_idx);
         end
      end
   end

   assign w_load_ok     = (r_state == ST_EMPTY) || !resend;
   assign w_take        = w_load_ok && w_grant_found && reset;
   assign w_accept      = (r_state == ST_FULL) && !resend;
   assign w_reject      = (r_state == ST_FULL) && resend;
   assign w_sel_addr    = req_addr[int'(w_grant_idx)*ADDR_SZ +: ADDR_SZ];
   assign w_sel_payload = req_payload[int'(w_grant_idx)*PAYLOAD_SZ +: PAYLOAD_SZ];

   always_comb begin
      req_ready = '0;
      if (w_take) begin
         req_ready[w_grant_idx] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dout_nxt  = r_dout;
      w_rr_nxt    = r_rr;
      w_last_nxt  = r_last;
      if (w_load_ok) begin
         if (w_take) begin
            w_state_nxt = ST_FULL;
            w_dout_nxt  = {1'b1, w_sel_addr, w_sel_payload};
            w_last_nxt  = w_grant_idx;
            w_rr_nxt    = (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + SRC_W'(1);
         end else begin
            w_state_nxt = ST_EMPTY;
            w_dout_nxt  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_EMPTY;
         r_dout  <= '0;
         r_rr    <= '0;
         r_last  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= w_dout_nxt;
         r_rr    <= w_rr_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Statistics saturate at all-ones rather than wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sent  <= '0;
         r_retry <= '0;
      end else begin
         if (w_accept && (r_sent != {CNT_SZ{1'b1}})) begin
            r_sent <= r_sent + CNT_SZ'(1);
         end
         if (w_reject && (r_retry != {CNT_SZ{1'b1}})) begin
            r_retry <= r_retry + CNT_SZ'(1);
         end
      end
   end

   assign dout_leaf = r_dout;
   assign busy      = r_dout[P_SZ-1];
   assign last_src  = r_last;
   assign sent_cnt  = r_sent;
   assign retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_leaf_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_leaf_tx_arbiter
//  Brief   : Scoreboard bench for leaf_tx_arbiter (16-bit and 4-bit counters).
//  Rev     : 1.0
// ============================================================================
module tb_leaf_tx_arbiter;

   localparam int N  = 4;
   localparam int AW = 3;
   localparam int PW = 45;
   localparam int PS = 49;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*PW-1:0] req_payload = '0;
   logic            resend = 1'b0;

   logic [N-1:0]  req_ready, req_ready_s;
   logic [PS-1:0] dout_leaf, dout_leaf_s;
   logic          busy, busy_s;
   logic [1:0]    last_src, last_src_s;
   logic [15:0]   sent_cnt, retry_cnt;
   logic [3:0]    sent_cnt_s, retry_cnt_s;

   always #5 clk = ~clk;

   leaf_tx_arbiter #(.NUM_REQ(N), .ADDR_SZ(AW), .PAYLOAD_SZ(PW), .P_SZ(PS), .CNT_SZ(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_payload(req_payload), .req_ready(req_ready), .dout_leaf(dout_leaf),
      .resend(resend), .busy(busy), .last_src(last_src), .sent_cnt(sent_cnt),
      .retry_cnt(retry_cnt));

   leaf_tx_arbiter #(.NUM_REQ(N), .ADDR_SZ(AW), .PAYLOAD_SZ(PW), .P_SZ(PS), .CNT_SZ(4)) dut_s (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_payload(req_payload), .req_ready(req_ready_s), .dout_leaf(dout_leaf_s),
      .resend(resend), .busy(busy_s), .last_src(last_src_s), .sent_cnt(sent_cnt_s),
      .retry_cnt(retry_cnt_s));

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0]    m_rr;
   bit            m_full;
   logic [PS-1:0] m_dout;
   logic [1:0]    m_last;
   int            m_sent;
   int            m_retry;
   int            last_g;
   logic [PS-1:0] sb_q[$];

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_rr = '0; m_full = 0; m_dout = '0; m_last = '0;
      m_sent = 0; m_retry = 0; last_g = 0;
      sb_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0; req_valid = '0; resend = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [PW-1:0] p);
      req_addr[i*AW +: AW]    = a;
      req_payload[i*PW +: PW] = p;
      req_valid[i]            = 1'b1;
   endtask

   function automatic logic [PW-1:0] rnd_payload();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[PW-1:0];
   endfunction

   // One clock: predict handshake, push expected packet, pop and compare after the edge
   task automatic step();
      int g;
      bit lok;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      lok = !m_full || !resend;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(m_rr) + k) % N;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (lok && g >= 0) begin
         exp_rdy[g] = 1'b1;
         sb_q.push_back({1'b1, req_addr[g*AW +: AW], req_payload[g*PW +: PW]});
      end
      n_cmp++;
      if (req_ready !== exp_rdy) begin
         n_bad++; $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
      end
      n_cmp++;
      if (req_ready_s !== exp_rdy) begin
         n_bad++; $display("FAIL req_ready_s: got %b want %b", req_ready_s, exp_rdy);
      end
      @(posedge clk);
      if (m_full && !resend) m_sent++;
      if (m_full && resend) m_retry++;
      if (lok) begin
         if (g >= 0) begin
            m_dout = sb_q.pop_front();
            m_full = 1;
            m_last = g[1:0];
            m_rr   = 2'((g + 1) % N);
            last_g = g;
         end else begin
            m_dout = '0;
            m_full = 0;
         end
      end
      #1;
      n_cmp++;
      if (dout_leaf !== m_dout) begin
         n_bad++; $display("FAIL dout_leaf: got %h want %h", dout_leaf, m_dout);
      end
      n_cmp++;
      if (dout_leaf_s !== m_dout) begin
         n_bad++; $display("FAIL dout_leaf_s: got %h want %h", dout_leaf_s, m_dout);
      end
      n_cmp++;
      if (busy !== m_full) begin
         n_bad++; $display("FAIL busy: got %b want %b", busy, m_full);
      end
      n_cmp++;
      if (last_src !== m_last) begin
         n_bad++; $display("FAIL last_src: got %0d want %0d", last_src, m_last);
      end
      n_cmp++;
      if (int'(sent_cnt) != sat(m_sent, 65535) || int'(sent_cnt_s) != sat(m_sent, 15)) begin
         n_bad++;
         $display("FAIL sent_cnt: got %0d/%0d want %0d/%0d", sent_cnt, sent_cnt_s,
                  sat(m_sent, 65535), sat(m_sent, 15));
      end
      n_cmp++;
      if (int'(retry_cnt) != sat(m_retry, 65535) || int'(retry_cnt_s) != sat(m_retry, 15)) begin
         n_bad++;
         $display("FAIL retry_cnt: got %0d/%0d want %0d/%0d", retry_cnt, retry_cnt_s,
                  sat(m_retry, 65535), sat(m_retry, 15));
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (dout_leaf !== '0 || busy !== 1'b0 || sent_cnt !== '0 || retry_cnt !== '0) begin
         n_bad++; $display("FAIL reset_state: got dout=%h busy=%b sent=%0d retry=%0d want 0",
                           dout_leaf, busy, sent_cnt, retry_cnt);
      end
      set_req(2, 3'd4, 45'h0AB_CDEF_0123);
      step();
      req_valid = 4'b0001;
      set_req(0, 3'd1, 45'h11);
      resend = 1'b1;
      step();
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (dout_leaf !== '0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL async_clear: got dout=%h busy=%b want 0/0", dout_leaf, busy);
      end
      n_cmp++;
      if (sent_cnt !== '0 || retry_cnt !== '0) begin
         n_bad++; $display("FAIL async_cnt: got sent=%0d retry=%0d want 0/0", sent_cnt, retry_cnt);
      end
      n_cmp++;
      if (req_ready !== '0) begin
         n_bad++; $display("FAIL ready_in_reset: got %b want 0000", req_ready);
      end
      req_valid = '1;
      #1;
      n_cmp++;
      if (req_ready !== '0 || last_src !== 2'd0) begin
         n_bad++; $display("FAIL ready_in_reset2: got %b src=%0d want 0000 src=0", req_ready, last_src);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      resend = 1'b0;
      model_reset();
      step();
      n_cmp++;
      if (last_src !== 2'd0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL first_grant: got src=%0d busy=%b want src=0 busy=1", last_src, busy);
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      set_req(2, 3'd5, 45'h1_2345_6789);
      step();
      n_cmp++;
      if (dout_leaf !== {1'b1, 3'd5, 45'h1_2345_6789} || last_src !== 2'd2) begin
         n_bad++; $display("FAIL single_pkt: got %h src=%0d want %h src=2",
                           dout_leaf, last_src, {1'b1, 3'd5, 45'h1_2345_6789});
      end
      req_valid = '0;
      step();
      n_cmp++;
      if (sent_cnt !== 16'd1 || dout_leaf[PS-1] !== 1'b0) begin
         n_bad++; $display("FAIL single_after: got sent=%0d valid=%b want 1/0", sent_cnt, dout_leaf[PS-1]);
      end
   endtask

   task automatic test_fairness();
      int order[$];
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 3'(i + 1), 45'(64'h100 * (i + 7)));
      for (int c = 0; c < 8; c++) begin
         step();
         order.push_back(int'(last_src));
      end
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (order[c] != c % N) begin
            n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", c, order[c], c % N);
         end
      end
      req_valid = '0;
      step();
      n_cmp++;
      if (sent_cnt !== 16'd8) begin
         n_bad++; $display("FAIL fair_sent: got %0d want 8", sent_cnt);
      end
   endtask

   task automatic test_resend_hold();
      logic [PS-1:0] held;
      do_reset();
      set_req(1, 3'd6, 45'h0DEAD_BEEF);
      set_req(3, 3'd2, 45'h15_5555_5555);
      step();
      held = dout_leaf;
      req_valid[1] = 1'b0;
      resend = 1'b1;
      repeat (3) begin
         step();
         n_cmp++;
         if (dout_leaf !== held) begin
            n_bad++; $display("FAIL hold_data: got %h want %h", dout_leaf, held);
         end
      end
      n_cmp++;
      if (retry_cnt !== 16'd3 || sent_cnt !== 16'd0) begin
         n_bad++; $display("FAIL hold_cnt: got retry=%0d sent=%0d want 3/0", retry_cnt, sent_cnt);
      end
      resend = 1'b0;
      step();
      n_cmp++;
      if (sent_cnt !== 16'd1 || last_src !== 2'd3 || dout_leaf !== {1'b1, 3'd2, 45'h15_5555_5555}) begin
         n_bad++; $display("FAIL accept_reload: got sent=%0d src=%0d dout=%h want 1/3/%h",
                           sent_cnt, last_src, dout_leaf, {1'b1, 3'd2, 45'h15_5555_5555});
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_resend_empty();
      do_reset();
      resend = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (retry_cnt !== 16'd0 || busy !== 1'b0 || dout_leaf !== '0) begin
         n_bad++; $display("FAIL resend_empty: got retry=%0d busy=%b dout=%h want 0/0/0",
                           retry_cnt, busy, dout_leaf);
      end
      resend = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(7)), rnd_payload());
      for (int c = 0; c < 20; c++) begin
         step();
         set_req(last_g, 3'($urandom_range(7)), rnd_payload());
      end
      req_valid = '0;
      step();
      n_cmp++;
      if (sent_cnt_s !== 4'd15 || sent_cnt !== 16'd20) begin
         n_bad++; $display("FAIL saturation: got %0d/%0d want 15/20", sent_cnt_s, sent_cnt);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_resend_hold();
      test_resend_empty();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
